// File: rtl/zcip_col_scheduler.sv
// Zero-column index processor: serialises one sign-magnitude weight group into
// sign column, magnitude bit-columns and a done pulse. Zero-column skipping is enabled by ZCIP_SKIP_EN.
module zcip_col_scheduler #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned ACT_W     = 8,
  parameter int unsigned W_W       = 8,
  parameter int unsigned SH_W      = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [NUM_LANES*W_W-1:0]     weights,
  input  logic [NUM_LANES*ACT_W-1:0]   acts_in,
  output logic [NUM_LANES*ACT_W-1:0]   activations,
  output logic [NUM_LANES-1:0]         weight_column,
  output logic                         weight_sign_en,
  output logic [SH_W-1:0]              shift_offset,
  output logic                         done,
  output logic                         busy,
  output logic [SH_W-1:0]              col_count
);

  localparam int unsigned MAG_W = W_W - 1;

  typedef enum logic [1:0] {IDLE, SIGN, COLS, FIN} state_t;

  state_t                       state_q;
  logic [MAG_W-1:0]             mag_q [NUM_LANES];
  logic [MAG_W-1:0]             mask_q;
  logic [SH_W-1:0]              cnt_q;

  logic                         w_ready_q;
  logic                         busy_q;
  logic [NUM_LANES-1:0]         col_q;
  logic                         sign_en_q;
  logic [SH_W-1:0]              shift_q;
  logic                         done_q;
  logic [NUM_LANES*ACT_W-1:0]   acts_q;
  logic [SH_W-1:0]              col_count_q;

  logic [MAG_W-1:0]             in_mask;
  logic [NUM_LANES-1:0]         in_sign;
  logic [SH_W-1:0]              k_sel;
  logic                         k_found;
  logic [NUM_LANES-1:0]         k_col;
  logic [MAG_W-1:0]             mask_d;

  // Column-occupancy mask and sign column of the incoming group.
  always_comb begin
    in_mask = '0;
    in_sign = '0;
    for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
      in_sign[lane] = weights[lane*W_W + W_W - 1];
      for (int unsigned k = 0; k < MAG_W; k++) begin
        in_mask[k] = in_mask[k] | weights[lane*W_W + k];
      end
    end
`ifndef ZCIP_SKIP_EN
    in_mask = '1;
`endif
  end

  // Lowest remaining column; clearing it is m & (m - 1).
  always_comb begin
    k_sel   = '0;
    k_found = 1'b0;
    for (int unsigned k = 0; k < MAG_W; k++) begin
      if (!k_found && mask_q[k]) begin
        k_sel   = SH_W'(k);
        k_found = 1'b1;
      end
    end
    k_col = '0;
    for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
      k_col[lane] = mag_q[lane][k_sel];
    end
    mask_d = mask_q & (mask_q - MAG_W'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mag_q       <= '{default: '0};
      mask_q      <= '0;
      cnt_q       <= '0;
      w_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      col_q       <= '0;
      sign_en_q   <= 1'b0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      acts_q      <= '0;
      col_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_valid) begin
            for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
              mag_q[lane] <= weights[lane*W_W +: MAG_W];
            end
            mask_q    <= in_mask;
            cnt_q     <= '0;
            acts_q    <= acts_in;
            col_q     <= in_sign;
            sign_en_q <= 1'b1;
            shift_q   <= '0;
            w_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SIGN;
          end
        end
        // Outputs are set on entry to a state, so SIGN and COLS share the
        // "issue next column or close the group" decision.
        SIGN, COLS: begin
          sign_en_q <= 1'b0;
          if (mask_q == '0) begin
            col_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b1;
            col_count_q <= cnt_q;
            state_q     <= FIN;
          end else begin
            col_q   <= k_col;
            shift_q <= k_sel;
            mask_q  <= mask_d;
            cnt_q   <= cnt_q + SH_W'(1);
            state_q <= COLS;
          end
        end
        FIN: begin
          done_q    <= 1'b0;
          w_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_ready        = w_ready_q;
  assign busy           = busy_q;
  assign weight_column  = col_q;
  assign weight_sign_en = sign_en_q;
  assign shift_offset   = shift_q;
  assign done           = done_q;
  assign activations    = acts_q;
  assign col_count      = col_count_q;

endmodule
